// File: rtl/pe_inst_sequencer_if.sv
// -----------------------------------------------------------------------------
// pe_inst_sequencer_if
//
// Bundles every non-clock/reset signal of pe_inst_sequencer.
//
// Signals:
//   start        run request, honoured only while the sequencer is idle
//   pause        global stall; freezes all sequencer state
//   neuron_base  neuron start address, captured when a run starts
//   weight_base  weight start address, captured when a run starts
//   inst_addr    instruction memory address (driven by the sequencer)
//   inst_data    iteration count read combinationally at inst_addr
//   neuron_addr  neuron memory address (driven by the sequencer)
//   weight_addr  weight memory address (driven by the sequencer)
//   pe_vld_i     beat valid to the PE
//   pe_ctl       bit0 = first beat of an instruction, bit1 = last beat
//   busy         sequencer is not idle
//   done         one-cycle pulse at the end of a run
//
// Modports:
//   master  the sequencer itself
//   slave   the environment (controller, memories, PE)
// -----------------------------------------------------------------------------
interface pe_inst_sequencer_if #(
    parameter int INST_AW = 2,
    parameter int ADDR_W  = 16,
    parameter int ITER_W  = 8
);
    logic                start;
    logic                pause;
    logic [ADDR_W-1:0]   neuron_base;
    logic [ADDR_W-1:0]   weight_base;
    logic [INST_AW-1:0]  inst_addr;
    logic [ITER_W-1:0]   inst_data;
    logic [ADDR_W-1:0]   neuron_addr;
    logic [ADDR_W-1:0]   weight_addr;
    logic                pe_vld_i;
    logic [1:0]          pe_ctl;
    logic                busy;
    logic                done;

    modport master (
        input  start, pause, neuron_base, weight_base, inst_data,
        output inst_addr, neuron_addr, weight_addr, pe_vld_i, pe_ctl, busy, done
    );

    modport slave (
        output start, pause, neuron_base, weight_base, inst_data,
        input  inst_addr, neuron_addr, weight_addr, pe_vld_i, pe_ctl, busy, done
    );
endinterface

// File: rtl/pe_inst_sequencer.sv
// -----------------------------------------------------------------------------
// pe_inst_sequencer
//
// Walks a small instruction memory in which each entry is an iteration count.
// For every instruction it spends one LOAD cycle fetching the count and then
// issues that many beats of neuron/weight addresses to a downstream PE, with
// first/last-beat markers on pe_ctl. Addresses run contiguously across all
// instructions of a run and wrap modulo 2^ADDR_W. An instruction with a count
// of zero costs one LOAD cycle and issues no beat. pause freezes every
// register and suppresses the beat of the current cycle.
//
// Ports:
//   clk    clock
//   rst_n  synchronous, active-low reset
//   bus    pe_inst_sequencer_if.master (start/pause/bases/instruction memory
//          in; instruction, neuron and weight addresses, PE strobes and
//          busy/done out)
// -----------------------------------------------------------------------------
module pe_inst_sequencer #(
    parameter int INST_NUM = 4,
    parameter int INST_AW  = 2,
    parameter int ADDR_W   = 16,
    parameter int ITER_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pe_inst_sequencer_if.master   bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [INST_AW-1:0] LAST_INST = INST_AW'(INST_NUM - 1);

    state_t              state, state_next;
    logic [INST_AW-1:0]  inst_addr_q, inst_addr_next;
    logic [ADDR_W-1:0]   neuron_addr_q, neuron_addr_next;
    logic [ADDR_W-1:0]   weight_addr_q, weight_addr_next;
    logic [ITER_W-1:0]   iter_q, iter_next;
    logic [ITER_W-1:0]   cnt_q, cnt_next;

    logic                last_inst;
    logic                first_beat;
    logic                last_beat;
    logic                pe_vld;
    logic [1:0]          pe_ctl;

    assign last_inst  = (inst_addr_q == LAST_INST);
    assign first_beat = (iter_q == '0);
    // cnt_q is never zero while in RUN, so cnt_q-1 cannot underflow there.
    assign last_beat  = (iter_q == (cnt_q - ITER_W'(1)));

    // Next-state and beat outputs.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_next       = state;
        inst_addr_next   = inst_addr_q;
        neuron_addr_next = neuron_addr_q;
        weight_addr_next = weight_addr_q;
        iter_next        = iter_q;
        cnt_next         = cnt_q;
        pe_vld           = 1'b0;
        pe_ctl           = 2'b00;

        // A paused cycle keeps every register as it is and issues no beat.
        if (!bus.pause) begin
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state_next       = S_LOAD;
                        neuron_addr_next = bus.neuron_base;
                        weight_addr_next = bus.weight_base;
                        inst_addr_next   = '0;
                        iter_next        = '0;
                    end
                end

                S_LOAD: begin
                    cnt_next  = bus.inst_data;
                    iter_next = '0;
                    if (bus.inst_data == '0) begin
                        // Empty instruction: skip straight to the next one.
                        if (last_inst) begin
                            state_next = S_DONE;
                        end else begin
                            inst_addr_next = inst_addr_q + INST_AW'(1);
                        end
                    end else begin
                        state_next = S_RUN;
                    end
                end

                S_RUN: begin
                    pe_vld           = 1'b1;
                    pe_ctl           = {last_beat, first_beat};
                    neuron_addr_next = neuron_addr_q + ADDR_W'(1);
                    weight_addr_next = weight_addr_q + ADDR_W'(1);
                    if (last_beat) begin
                        iter_next = '0;
                        if (last_inst) begin
                            state_next = S_DONE;
                        end else begin
                            inst_addr_next = inst_addr_q + INST_AW'(1);
                            state_next     = S_LOAD;
                        end
                    end else begin
                        iter_next = iter_q + ITER_W'(1);
                    end
                end

                S_DONE: begin
                    state_next = S_IDLE;
                end

                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every register samples the pre-edge values, whatever the order.
        if (!rst_n) begin
            state         <= S_IDLE;
            inst_addr_q   <= '0;
            neuron_addr_q <= '0;
            weight_addr_q <= '0;
            iter_q        <= '0;
            cnt_q         <= '0;
        end else begin
            state         <= state_next;
            inst_addr_q   <= inst_addr_next;
            neuron_addr_q <= neuron_addr_next;
            weight_addr_q <= weight_addr_next;
            iter_q        <= iter_next;
            cnt_q         <= cnt_next;
        end
    end

    assign bus.inst_addr   = inst_addr_q;
    assign bus.neuron_addr = neuron_addr_q;
    assign bus.weight_addr = weight_addr_q;
    assign bus.pe_vld_i    = pe_vld;
    assign bus.pe_ctl      = pe_ctl;
    assign bus.busy        = (state != S_IDLE);
    // done is held while DONE is paused, since the state itself is held.
    assign bus.done        = (state == S_DONE);

endmodule

// File: tb/tb_pe_inst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pe_inst_sequencer
//
// Directed bench for pe_inst_sequencer. Each run drives start in relative
// cycle 0 and records beats, LOAD cycles, done cycles and the busy fall
// against that cycle number; expectations are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_pe_inst_sequencer;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pe_inst_sequencer_if #(.INST_AW(2), .ADDR_W(16), .ITER_W(8)) bus ();

    pe_inst_sequencer #(
        .INST_NUM (4),
        .INST_AW  (2),
        .ADDR_W   (16),
        .ITER_W   (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Instruction memory model with combinational read.
    logic [7:0] imem [4];
    assign bus.inst_data = imem[bus.inst_addr];

    typedef struct {
        int          cyc;
        logic [15:0] na;
        logic [15:0] wa;
        logic [1:0]  ctl;
    } beat_t;

    beat_t beats [$];
    int    loads [$];
    int    dones [$];
    int    n_beats, n_loads, n_dones;
    int    busy_fall;
    int    vld_in_pause;
    int    hold_bad;
    logic [15:0] pause_na;

    logic        snap_vld, snap_busy, snap_done;
    logic [1:0]  snap_ctl, snap_ia;
    logic [15:0] snap_na, snap_wa;

    int checks = 0;
    int errors = 0;

    int exp_ctl2 [5] = '{3, 1, 0, 2, 3};
    int exp_cyc2 [5] = '{2, 5, 6, 7, 9};
    int exp_load [4] = '{1, 22, 53, 94};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Count beats whose neuron or weight address is not base+index.
    function automatic int addr_seq_bad(input logic [15:0] base, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            if (beats[i].na !== base + 16'(i) || beats[i].wa !== base + 16'(i)) bad++;
        end
        return bad;
    endfunction

    // One run: start in relative cycle 0, optional pause window, up to two
    // extra start pulses and an optional one-cycle reset. Stops one cycle
    // after done (to see busy fall) or after max_cyc cycles.
    task automatic run_prog(input logic [15:0] nb, input logic [15:0] wb,
                            input int pause_from, input int pause_len,
                            input int xs_a, input int xs_b,
                            input int rst_at, input int max_cyc);
        int   rel;
        logic prev_pause;
        beats.delete();
        loads.delete();
        dones.delete();
        busy_fall    = -1;
        vld_in_pause = 0;
        hold_bad     = 0;
        pause_na     = 16'hDEAD;
        prev_pause   = 1'b0;

        @(posedge clk);
        #2;
        bus.neuron_base = nb;
        bus.weight_base = wb;
        bus.start       = 1'b1;
        rel             = 0;
        while (rel < max_cyc) begin
            @(negedge clk);
            if (bus.pe_vld_i)
                beats.push_back('{rel, bus.neuron_addr, bus.weight_addr, bus.pe_ctl});
            if (bus.busy && !bus.pe_vld_i && !bus.done && !bus.pause)
                loads.push_back(rel);
            if (bus.done)
                dones.push_back(rel);
            if (!bus.busy && rel > 0 && busy_fall < 0)
                busy_fall = rel;
            if (bus.pause) begin
                if (bus.pe_vld_i) vld_in_pause++;
                if (!prev_pause) pause_na = bus.neuron_addr;
                else if (bus.neuron_addr !== pause_na) hold_bad++;
            end
            prev_pause = bus.pause;
            if (rel == rst_at + 1) begin
                snap_vld  = bus.pe_vld_i;
                snap_ctl  = bus.pe_ctl;
                snap_busy = bus.busy;
                snap_done = bus.done;
                snap_ia   = bus.inst_addr;
                snap_na   = bus.neuron_addr;
                snap_wa   = bus.weight_addr;
            end
            if (dones.size() > 0 && rel >= dones[0] + 1) break;
            @(posedge clk);
            #2;
            rel++;
            bus.start = (rel == xs_a) || (rel == xs_b);
            bus.pause = (rel >= pause_from) && (rel < pause_from + pause_len);
            rst_n     = (rel != rst_at);
        end
        bus.start = 1'b0;
        bus.pause = 1'b0;
        rst_n     = 1'b1;

        n_beats = beats.size();
        n_loads = loads.size();
        n_dones = dones.size();
        // Pad so fixed indices stay readable even when counts come up short.
        while (beats.size() < 300) beats.push_back('{-1, 16'h0, 16'h0, 2'b00});
        while (loads.size() < 8)   loads.push_back(-1);
        while (dones.size() < 2)   dones.push_back(-1);
        repeat (2) @(posedge clk);
    endtask

    task automatic set_imem(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
        imem[0] = a;
        imem[1] = b;
        imem[2] = c;
        imem[3] = d;
    endtask

    task automatic check_first_scenario(input string p);
        check({p, "_done_cnt"},  n_dones, 1);
        check({p, "_done_cyc"},  dones[0], 145);
        check({p, "_beats"},     n_beats, 140);
        check({p, "_loads"},     n_loads, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s_load%0d", p, i), loads[i], exp_load[i]);
        check({p, "_first_cyc"}, beats[0].cyc, 2);
        check({p, "_first_ctl"}, beats[0].ctl, 2'b01);
        check({p, "_i0_end"},    beats[19].cyc, 21);
        check({p, "_i0_endctl"}, beats[19].ctl, 2'b10);
        check({p, "_i1_beg"},    beats[20].cyc, 23);
        check({p, "_last_cyc"},  beats[139].cyc, 144);
        check({p, "_last_na"},   beats[139].na, 139);
        check({p, "_last_wa"},   beats[139].wa, 139);
        check({p, "_last_ctl"},  beats[139].ctl, 2'b10);
        check({p, "_addr_seq"},  addr_seq_bad(16'h0000, 140), 0);
        check({p, "_busy_fall"}, busy_fall, 146);
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.pause       = 1'b0;
        bus.neuron_base = 16'h0;
        bus.weight_base = 16'h0;
        set_imem(8'd0, 8'd0, 8'd0, 8'd0);

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_vld",  bus.pe_vld_i, 0);
        check("rst_ctl",  bus.pe_ctl, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_ia",   bus.inst_addr, 0);
        check("rst_na",   bus.neuron_addr, 0);
        check("rst_wa",   bus.weight_addr, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Scenario 1: {20,30,40,50}, bases 0.
        set_imem(8'd20, 8'd30, 8'd40, 8'd50);
        run_prog(16'h0000, 16'h0000, -1, 0, -1, -1, -1, 400);
        check_first_scenario("s1");

        // Scenario 2: {1,0,3,1}, distinct neuron/weight bases.
        set_imem(8'd1, 8'd0, 8'd3, 8'd1);
        run_prog(16'h0100, 16'h0200, -1, 0, -1, -1, -1, 60);
        check("s2_beats",    n_beats, 5);
        check("s2_done_cyc", dones[0], 10);
        check("s2_loads",    n_loads, 4);
        check("s2_load_empty", loads[1], 3);
        check("s2_load3",    loads[3], 8);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("s2_ctl%0d", i), beats[i].ctl, exp_ctl2[i]);
            check($sformatf("s2_cyc%0d", i), beats[i].cyc, exp_cyc2[i]);
            check($sformatf("s2_na%0d", i),  beats[i].na, 16'h0100 + 16'(i));
            check($sformatf("s2_wa%0d", i),  beats[i].wa, 16'h0200 + 16'(i));
        end

        // Scenario 3: address wrap from 0xFFFE.
        set_imem(8'd4, 8'd0, 8'd0, 8'd0);
        run_prog(16'hFFFE, 16'hFFFE, -1, 0, -1, -1, -1, 60);
        check("s3_beats",    n_beats, 4);
        check("s3_na0",      beats[0].na, 16'hFFFE);
        check("s3_na1",      beats[1].na, 16'hFFFF);
        check("s3_na2",      beats[2].na, 16'h0000);
        check("s3_na3",      beats[3].na, 16'h0001);
        check("s3_wa3",      beats[3].wa, 16'h0001);
        check("s3_ctl3",     beats[3].ctl, 2'b10);
        check("s3_done_cyc", dones[0], 9);

        // Scenario 4: pause for cycles 30..32 inside instruction 1.
        set_imem(8'd20, 8'd30, 8'd40, 8'd50);
        run_prog(16'h0000, 16'h0000, 30, 3, -1, -1, -1, 400);
        check("s4_beats",      n_beats, 140);
        check("s4_vld_paused", vld_in_pause, 0);
        check("s4_hold",       hold_bad, 0);
        check("s4_pause_na",   pause_na, 27);
        check("s4_pre_cyc",    beats[26].cyc, 29);
        check("s4_resume_cyc", beats[27].cyc, 33);
        check("s4_resume_na",  beats[27].na, 27);
        check("s4_resume_ctl", beats[27].ctl, 2'b00);
        check("s4_i1_end_cyc", beats[49].cyc, 55);
        check("s4_i1_end_ctl", beats[49].ctl, 2'b10);
        check("s4_addr_seq",   addr_seq_bad(16'h0000, 140), 0);
        check("s4_done_cyc",   dones[0], 148);

        // Scenario 5: start pulses while busy are ignored.
        run_prog(16'h0000, 16'h0000, -1, 0, 10, 60, -1, 400);
        check_first_scenario("s5");

        // Scenario 6: one-cycle reset during instruction 1, then a fresh run.
        run_prog(16'h0000, 16'h0000, -1, 0, -1, -1, 30, 45);
        check("s6_vld",   snap_vld, 0);
        check("s6_ctl",   snap_ctl, 0);
        check("s6_busy",  snap_busy, 0);
        check("s6_done",  snap_done, 0);
        check("s6_ia",    snap_ia, 0);
        check("s6_na",    snap_na, 0);
        check("s6_wa",    snap_wa, 0);
        check("s6_no_done", n_dones, 0);
        run_prog(16'h0000, 16'h0000, -1, 0, -1, -1, -1, 400);
        check_first_scenario("s6r");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_inst_sequencer.md
# pe_inst_sequencer

Instruction-driven sequencer that sits directly upstream of `parallel_pe`. It walks a small instruction memory where each entry is an 8-bit iteration count. For each instruction it issues that many beats of neuron/weight addresses, plus the `vld_i`/`ctl` strobes the PE consumes. Neuron and weight memories are external with combinational read, so data arrives at the PE in the same cycle as the address.

## Interface
- `INST_NUM`, 4: number of instructions executed per run.
- `INST_AW`, 2: instruction address width; must satisfy 2^INST_AW >= INST_NUM.
- `ADDR_W`, 16: neuron/weight address width.
- `ITER_W`, 8: iteration counter and instruction data width.

Ports:
- `clk`  in  1  clock, one domain.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  run request; sampled only in IDLE.
- `pause`  in  1  freezes all state; no beat is issued while high.
- `neuron_base`  in  ADDR_W  neuron start address, latched on accepted start.
- `weight_base`  in  ADDR_W  weight start address, latched on accepted start.
- `inst_addr`  out  INST_AW  instruction memory address (registered).
- `inst_data`  in  ITER_W  iteration count at `inst_addr`, combinational read.
- `neuron_addr`  out  ADDR_W  neuron memory address (registered).
- `weight_addr`  out  ADDR_W  weight memory address (registered).
- `pe_vld_i`  out  1  beat valid to the PE.
- `pe_ctl`  out  2  bit0 = first beat of an instruction; bit1 = last beat.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle pulse when a run completes.

## Operation
- FSM states:
  - IDLE: outputs quiet; `start` → LOAD; latch bases; `inst_addr`=0; `iter`=0.
  - LOAD: sample `inst_data` into `cnt`.
    - If `inst_data`==0 (empty instruction): no beats issued.
      - If `inst_addr`==INST_NUM-1 → DONE.
      - Otherwise `inst_addr`+1, stay in LOAD.
    - If `inst_data`!=0 → RUN with `iter`=0.
  - RUN: each unpaused cycle is one beat.
    - `pe_vld_i`=1; `pe_ctl[0]` = (`iter`==0); `pe_ctl[1]` = (`iter`==`cnt`-1).
    - After each beat, `neuron_addr` and `weight_addr` each +1 and `iter`+1.
    - On the last beat: `iter`←0.
      - If `inst_addr`==INST_NUM-1 → DONE.
      - Otherwise `inst_addr`+1 → LOAD.
  - DONE: `done`=1 for one cycle → IDLE.
- Addresses run contiguously across instructions and are not reset between instructions.
- Address arithmetic wraps modulo 2^ADDR_W with no error flag.
- `pe_vld_i` and `pe_ctl` are combinational from state, `iter`, `cnt` and `pause`. `pe_ctl` is 0 whenever `pe_vld_i`=0.
- `cnt`==1: `pe_ctl`=2'b11 on the single beat.
- `cnt`==255: 255 beats, `iter` never wraps.
- `pause` high in any state holds every register.
  - In RUN it forces `pe_vld_i`=0 and the beat is deferred.
  - In IDLE the `start` request is ignored.
  - In DONE `done` stays asserted until `pause` drops.
- `start` while `busy` is ignored; no restart or queueing.
- Reset values (`rst_n` low at a clock edge):
  - state IDLE.
  - `inst_addr`, `neuron_addr`, `weight_addr`, `iter`, `cnt` all 0.
  - `pe_vld_i`, `pe_ctl`, `busy`, `done` all 0.
  - Reset mid-RUN abandons the run; no `done` pulse is issued.

## Timing
- Start accepted at edge E. LOAD occupies cycle E+1 and the first beat is in cycle E+2.
- Each instruction costs 1 LOAD bubble + `cnt` beats. An empty instruction costs 1 LOAD cycle.
- `done` asserts in the cycle after the final beat. `busy` falls one cycle after `done`.
- `inst_data` must be stable during LOAD. Neuron/weight data must be valid in the same cycle as the address.
- No back-pressure from the PE. `pause` is the only stall.

## Test plan
- Instructions {20,30,40,50}, bases 0, start in cycle 0:
  - LOAD cycles at 1, 22, 53, 94.
  - Beats at 2–21, 23–52, 54–93, 95–144.
  - `done` at 145; 140 beats total.
  - Last beat has `neuron_addr`=`weight_addr`=139 and `pe_ctl`=2'b10.
- Instructions {1,0,3,1}:
  - Beats carry `pe_ctl` = 11, then 01, 00, 10, then 11.
  - Instruction 1 consumes one LOAD cycle and produces no beat.
  - `done` after 5 beats.
- Bases 0xFFFE, instructions {4,0,0,0}: addresses go FFFE, FFFF, 0000, 0001, then `done`.
- `pause` high for 3 cycles mid-instruction:
  - `pe_vld_i`=0 and addresses/`iter` held during the pause.
  - Beat sequence resumes unchanged; total beat count is identical.
- `start` pulsed during RUN: ignored, with no change to addresses or counts.
- `rst_n` low for 1 cycle during the second instruction:
  - All outputs 0 the next cycle; no `done`.
  - A fresh `start` reproduces the first scenario's timing.
